// File: rtl/yuv_fb_pkg.sv
// yuv_fb_pkg: packing constants, state encoding and byte-order helpers shared by the
// YUV frame buffer writer and reader. Byte k of a buffer word sits at bits [8k+7:8k].
package yuv_fb_pkg;
    localparam int Y_PER_WORD = 5;
    localparam int C_PER_WORD = 18;
    localparam int YW_BITS = 40;
    localparam int CW_BITS = 144;
    localparam int A1_BITS = 16;
    localparam int A2_BITS = 13;

    typedef enum logic [1:0] {IDLE, FETCH, STREAM, LAST} rd_state_e;

    function automatic logic [7:0] y_byte(logic [YW_BITS-1:0] w, logic [2:0] k);
        return 8'(w >> {k, 3'b000});
    endfunction

    function automatic logic [7:0] c_byte(logic [CW_BITS-1:0] w, logic [4:0] k);
        return 8'(w >> {k, 3'b000});
    endfunction
endpackage

// File: rtl/yuv_frame_reader_if.sv
// yuv_frame_reader_if: raster pixel stream with valid/ready handshake and frame markers.
interface yuv_frame_reader_if;
    logic [7:0] pix_y;
    logic [7:0] pix_u;
    logic [7:0] pix_v;
    logic       pix_valid;
    logic       pix_ready;
    logic       pix_sof;
    logic       pix_eol;

    modport master(output pix_y, pix_u, pix_v, pix_valid, pix_sof, pix_eol, input pix_ready);
    modport slave(input pix_y, pix_u, pix_v, pix_valid, pix_sof, pix_eol, output pix_ready);
endinterface

// File: rtl/yuv_plane_cursor.sv
// yuv_plane_cursor: word/byte position inside one packed plane, advanced by increment only,
// with a single save/restore slot so a row of chroma can be replayed.
module yuv_plane_cursor #(
    parameter int PER_WORD = 5,
    parameter int AW = 16,
    parameter int BW = $clog2(PER_WORD)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          adv_i,
    input  logic          save_i,
    input  logic          restore_i,
    output logic [AW-1:0] word_o,
    output logic [BW-1:0] byte_o,
    output logic          wrap_o
);
    logic [AW-1:0] word_q, word_d, sv_word_q, sv_word_d;
    logic [BW-1:0] byte_q, byte_d, sv_byte_q, sv_byte_d;

    always_comb begin
        wrap_o = byte_q == BW'(PER_WORD - 1);
        word_d = clr_i ? '0 : restore_i ? sv_word_q : (adv_i && wrap_o) ? word_q + 1'b1 : word_q;
        byte_d = clr_i ? '0 : restore_i ? sv_byte_q : adv_i ? (wrap_o ? '0 : byte_q + 1'b1) : byte_q;
        sv_word_d = clr_i ? '0 : save_i ? word_d : sv_word_q;
        sv_byte_d = clr_i ? '0 : save_i ? byte_d : sv_byte_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            word_q <= '0;
            byte_q <= '0;
            sv_word_q <= '0;
            sv_byte_q <= '0;
        end else begin
            word_q <= word_d;
            byte_q <= byte_d;
            sv_word_q <= sv_word_d;
            sv_byte_q <= sv_byte_d;
        end

    assign word_o = word_q;
    assign byte_o = byte_q;
endmodule

// File: rtl/yuv_frame_reader.sv
// yuv_frame_reader: streams one YUV 4:2:0 frame in raster order out of the packed Y and U/V buffers.
// Define READER_FRAME_LOOP_EN to restart straight into the next frame when start is high at the last accept.
module yuv_frame_reader
    import yuv_fb_pkg::*;
#(
    parameter int WIDTH = 320,
    parameter int HEIGHT = 240,
    parameter int RD_LATENCY = 2,
    parameter int Y_BASE = 0,
    parameter int U_BASE = 0,
    parameter int V_BASE = 4096
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic               start,
    input  logic               abort,
    output logic [A1_BITS-1:0] rdaddress1,
    input  logic [YW_BITS-1:0] q1,
    output logic [A2_BITS-1:0] rdaddress2,
    input  logic [CW_BITS-1:0] q2,
    yuv_frame_reader_if.master pix,
    output logic               busy,
    output logic               frame_done
);
    localparam int XW = $clog2(WIDTH);
    localparam int YH = $clog2(HEIGHT);

    rd_state_e state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YH-1:0] y_q, y_d;
    logic [2:0] f_q, f_d;
    logic need_y_q, need_y_d, need_c_q, need_c_d;
    logic [YW_BITS-1:0] yw_q, yw_d;
    logic [CW_BITS-1:0] uw_q, uw_d, vw_q, vw_d;
    logic [A1_BITS-1:0] y_word;
    logic [2:0] y_idx;
    logic [A2_BITS-1:0] c_word;
    logic [4:0] c_idx;
    logic y_wrap, c_wrap, acc, last_x, last_px, again, restart, fetch_end;

`ifdef READER_FRAME_LOOP_EN
    logic loop_q;
    always_ff @(posedge CLOCK_50 or negedge RESET_N)
        if (!RESET_N) loop_q <= 1'b0;
        else if (acc && last_px) loop_q <= start;
    assign restart = loop_q;
`else
    assign restart = 1'b0;
`endif

    assign acc = state_q == STREAM && pix.pix_ready && !abort;
    assign last_x = x_q == XW'(WIDTH - 1);
    assign last_px = last_x && y_q == YH'(HEIGHT - 1);
    assign again = !abort && ((state_q == IDLE && start) || (state_q == LAST && restart));
    assign fetch_end = f_q == 3'(RD_LATENCY) + {2'b00, need_c_q};

    // Odd rows replay the chroma of the even row above: save entering even rows, restore entering odd ones.
    yuv_plane_cursor #(.PER_WORD(Y_PER_WORD), .AW(A1_BITS)) u_y_cur (
        .clk(CLOCK_50), .rst_n(RESET_N), .clr_i(again), .adv_i(acc), .save_i(1'b0), .restore_i(1'b0),
        .word_o(y_word), .byte_o(y_idx), .wrap_o(y_wrap)
    );

    yuv_plane_cursor #(.PER_WORD(C_PER_WORD), .AW(A2_BITS)) u_c_cur (
        .clk(CLOCK_50), .rst_n(RESET_N), .clr_i(again), .adv_i(acc && x_q[0]),
        .save_i(acc && last_x && y_q[0]), .restore_i(acc && last_x && !y_q[0]),
        .word_o(c_word), .byte_o(c_idx), .wrap_o(c_wrap)
    );

    always_comb begin
        state_d = state_q;
        x_d = x_q;
        y_d = y_q;
        f_d = '0;
        need_y_d = need_y_q;
        need_c_d = need_c_q;
        yw_d = yw_q;
        uw_d = uw_q;
        vw_d = vw_q;
        if (state_q == FETCH) begin
            f_d = fetch_end ? 3'd0 : f_q + 3'd1;
            state_d = fetch_end ? STREAM : FETCH;
            yw_d = (need_y_q && f_q == 3'(RD_LATENCY)) ? q1 : yw_q;
            uw_d = (need_c_q && f_q == 3'(RD_LATENCY)) ? q2 : uw_q;
            vw_d = (need_c_q && f_q == 3'(RD_LATENCY + 1)) ? q2 : vw_q;
        end
        if (acc) begin
            x_d = last_x ? '0 : x_q + 1'b1;
            y_d = last_x ? y_q + 1'b1 : y_q;
            need_y_d = y_wrap;
            need_c_d = (x_q[0] && c_wrap) || (last_x && !y_q[0]);
            state_d = last_px ? LAST : (need_y_d || need_c_d) ? FETCH : STREAM;
        end
        if (state_q == LAST) state_d = IDLE;
        if (again) begin
            state_d = FETCH;
            x_d = '0;
            y_d = '0;
            need_y_d = 1'b1;
            need_c_d = 1'b1;
        end
        if (abort) begin
            state_d = IDLE;
            f_d = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N)
        if (!RESET_N) begin
            state_q <= IDLE;
            x_q <= '0;
            y_q <= '0;
            f_q <= '0;
            need_y_q <= 1'b0;
            need_c_q <= 1'b0;
            yw_q <= '0;
            uw_q <= '0;
            vw_q <= '0;
        end else begin
            state_q <= state_d;
            x_q <= x_d;
            y_q <= y_d;
            f_q <= f_d;
            need_y_q <= need_y_d;
            need_c_q <= need_c_d;
            yw_q <= yw_d;
            uw_q <= uw_d;
            vw_q <= vw_d;
        end

    // The U read goes out on the first fetch cycle, V from the second on.
    assign rdaddress1 = A1_BITS'(Y_BASE) + y_word;
    assign rdaddress2 = (f_q == 3'd0 ? A2_BITS'(U_BASE) : A2_BITS'(V_BASE)) + c_word;
    assign busy = state_q != IDLE;
    assign frame_done = state_q == LAST;
    assign pix.pix_valid = state_q == STREAM;
    assign pix.pix_y = y_byte(yw_q, y_idx);
    assign pix.pix_u = c_byte(uw_q, c_idx);
    assign pix.pix_v = c_byte(vw_q, c_idx);
    assign pix.pix_sof = pix.pix_valid && x_q == '0 && y_q == '0;
    assign pix.pix_eol = pix.pix_valid && last_x;
endmodule
